// File: rtl/suma_serial.sv
// Bit-serial ripple adder: s = a + b, one bit per clock, LSB first.
// Optional signed-overflow output ovf when OVERFLOW_FLAG_EN is defined.
module suma_serial #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             cout
`ifdef OVERFLOW_FLAG_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] acc;
    logic             carry;
    logic [CW-1:0]    count;

    logic sum_bit;
    logic carry_nxt;

    // One full-adder slice, reused every cycle on the low bits.
    assign sum_bit   = a_sh[0] ^ b_sh[0] ^ carry;
    assign carry_nxt = (a_sh[0] & b_sh[0]) | (a_sh[0] & carry) | (b_sh[0] & carry);

    // Control FSM plus serial datapath; all outputs registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            a_sh  <= '0;
            b_sh  <= '0;
            acc   <= '0;
            carry <= 1'b0;
            count <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            s     <= '0;
            cout  <= 1'b0;
`ifdef OVERFLOW_FLAG_EN
            ovf   <= 1'b0;
`endif
        end else begin
            unique case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        acc   <= '0;
                        carry <= 1'b0;
                        count <= '0;
                        busy  <= 1'b1;
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    acc   <= {sum_bit, acc[WIDTH-1:1]};
                    a_sh  <= a_sh >> 1;
                    b_sh  <= b_sh >> 1;
                    carry <= carry_nxt;
                    count <= count + CW'(1);
                    if (count == CW'(WIDTH - 1)) begin
                        s     <= {sum_bit, acc[WIDTH-1:1]};
                        cout  <= carry_nxt;
`ifdef OVERFLOW_FLAG_EN
                        // carry into MSB differs from carry out -> signed overflow
                        ovf   <= carry ^ carry_nxt;
`endif
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_suma_serial.sv
// Self-checking bench for suma_serial: vector table, scoreboard queue,
// hand-written sequences for ignored start, mid-op reset and back-to-back.
module tb_suma_serial;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic         busy;
    logic         done;
    logic [W-1:0] s;
    logic         cout;
`ifdef OVERFLOW_FLAG_EN
    logic         ovf;
`endif

    suma_serial #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a_in),
        .b     (b_in),
        .busy  (busy),
        .done  (done),
        .s     (s),
        .cout  (cout)
`ifdef OVERFLOW_FLAG_EN
        ,
        .ovf   (ovf)
`endif
    );

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] s;
        logic         c;
        logic         v;
    } vec_t;

    typedef struct {
        logic [W-1:0] s;
        logic         c;
        logic         v;
    } exp_t;

    exp_t         q[$];
    int           tests;
    int           fails;
    int           done_cnt;
    int           cyc;
    logic [W-1:0] last_s;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: every done pulse pops one expected result.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && done) begin
            done_cnt++;
            if (q.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                e = q.pop_front();
                chk("s", 32'(s), 32'(e.s));
                chk("cout", 32'(cout), 32'(e.c));
`ifdef OVERFLOW_FLAG_EN
                chk("ovf", 32'(ovf), 32'(e.v));
`endif
                last_s = e.s;
            end
        end
    end

    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] es, input logic ec, input logic ev);
        int   n;
        exp_t e;
        @(negedge clk);
        a_in  = a;
        b_in  = b;
        start = 1'b1;
        e.s = es;
        e.c = ec;
        e.v = ev;
        q.push_back(e);
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", 32'(busy), 1);
        n = 0;
        while (busy && n < 50) begin
            n++;
            @(negedge clk);
        end
        chk("busy_cycles", n, W);
        chk("done_high", 32'(done), 1);
        @(negedge clk);
        chk("done_pulse_1cyc", 32'(done), 0);
    endtask

    vec_t vt[8];

    initial begin
        int           d0;
        int           seen;
        int           guard;
        int           t[3];
        logic [W:0]   full;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        exp_t         e;

        vt[0] = '{8'h25, 8'h13, 8'h38, 1'b0, 1'b0};
        vt[1] = '{8'hFF, 8'h01, 8'h00, 1'b1, 1'b0};
        vt[2] = '{8'hF0, 8'h20, 8'h10, 1'b1, 1'b0};
        vt[3] = '{8'h7F, 8'h01, 8'h80, 1'b0, 1'b1};
        vt[4] = '{8'h00, 8'h00, 8'h00, 1'b0, 1'b0};
        vt[5] = '{8'hFF, 8'hFF, 8'hFE, 1'b1, 1'b0};
        vt[6] = '{8'h80, 8'h80, 8'h00, 1'b1, 1'b1};
        vt[7] = '{8'hAA, 8'h55, 8'hFF, 1'b0, 1'b0};

        tests    = 0;
        fails    = 0;
        done_cnt = 0;
        cyc      = 0;
        last_s   = '0;
        start    = 1'b0;
        a_in     = '0;
        b_in     = '0;
        rst      = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_s", 32'(s), 0);
        chk("rst_cout", 32'(cout), 0);
        rst = 1'b0;

        for (int i = 0; i < 8; i++)
            do_op(vt[i].a, vt[i].b, vt[i].s, vt[i].c, vt[i].v);

        // random operands against an independent arithmetic model
        for (int i = 0; i < 6; i++) begin
            ra   = W'($urandom);
            rb   = W'($urandom);
            full = {1'b0, ra} + {1'b0, rb};
            do_op(ra, rb, full[W-1:0], full[W],
                  (ra[W-1] == rb[W-1]) && (full[W-1] != ra[W-1]));
        end

        // start re-pulsed during RUN is ignored; s holds previous result
        @(negedge clk);
        d0    = done_cnt;
        a_in  = 8'h01;
        b_in  = 8'h02;
        start = 1'b1;
        e.s = 8'h03;
        e.c = 1'b0;
        e.v = 1'b0;
        q.push_back(e);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        a_in  = 8'h55;
        b_in  = 8'h55;
        start = 1'b1;
        chk("s_hold_in_run", 32'(s), 32'(last_s));
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        chk("ignored_start_one_done", done_cnt - d0, 1);

        // reset in the middle of an operation aborts it
        @(negedge clk);
        a_in  = 8'h80;
        b_in  = 8'h80;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_busy", 32'(busy), 0);
        chk("abort_done", 32'(done), 0);
        chk("abort_s", 32'(s), 0);
        chk("abort_cout", 32'(cout), 0);
        @(negedge clk);
        rst = 1'b0;
        d0  = done_cnt;
        repeat (15) @(negedge clk);
        chk("abort_no_done", done_cnt - d0, 0);
        do_op(8'h80, 8'h80, 8'h00, 1'b1, 1'b1);

        // start held high: new operation every W+2 cycles
        e.s = 8'h10;
        e.c = 1'b0;
        e.v = 1'b0;
        for (int i = 0; i < 3; i++) q.push_back(e);
        @(negedge clk);
        a_in  = 8'h0F;
        b_in  = 8'h01;
        start = 1'b1;
        seen  = 0;
        guard = 0;
        while (seen < 3 && guard < 100) begin
            @(negedge clk);
            guard++;
            if (done) begin
                t[seen] = cyc;
                seen++;
            end
        end
        start = 1'b0;
        chk("b2b_done_count", seen, 3);
        if (seen == 3) begin
            chk("b2b_spacing_1", t[1] - t[0], W + 2);
            chk("b2b_spacing_2", t[2] - t[1], W + 2);
        end
        repeat (15) @(negedge clk);
        chk("sb_empty", q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
